// File: rtl/fabric_reset_sequencer_if.sv
// Lock input, software reset request and staged reset outputs of the fabric reset sequencer.
interface fabric_reset_sequencer_if;
    logic       CCC_LOCK;
    logic       SW_RESET_REQ;
    logic       FAB_RESET_N;
    logic       PERIPH_RESET_N;
    logic       READY;
    logic [7:0] LOCK_LOST_CNT;

    modport master (
        output CCC_LOCK,
        output SW_RESET_REQ,
        input  FAB_RESET_N,
        input  PERIPH_RESET_N,
        input  READY,
        input  LOCK_LOST_CNT
    );

    modport slave (
        input  CCC_LOCK,
        input  SW_RESET_REQ,
        output FAB_RESET_N,
        output PERIPH_RESET_N,
        output READY,
        output LOCK_LOST_CNT
    );
endinterface

// File: rtl/fabric_reset_sequencer.sv
// Staged fabric/peripheral reset release driven by a synchronized CCC lock, with
// re-assertion on lock loss or software request and a saturating lock-loss counter.
//
// state     | meaning
// WAIT_LOCK | both resets asserted, waiting for lock_s
// STABLE    | both resets asserted, lock_s must stay high STABLE_CYCLES cycles
// GAP       | fabric released, peripherals held STAGE_GAP cycles
// RUN       | everything released, READY high
// SW_HOLD   | both resets held SW_HOLD_CYCLES cycles after a software request
module fabric_reset_sequencer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned STAGE_GAP      = 16,
    parameter int unsigned SW_HOLD_CYCLES = 32
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    fabric_reset_sequencer_if.slave  bus
);

    localparam logic [2:0] WAIT_LOCK = 3'd0;
    localparam logic [2:0] STABLE    = 3'd1;
    localparam logic [2:0] GAP       = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] SW_HOLD   = 3'd4;

    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST    = 16'(STAGE_GAP - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(SW_HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0]             state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   fab_q, fab_d;
    logic                   periph_q, periph_d;
    logic                   ready_q, ready_d;
    logic [7:0]             lost_q, lost_d;
    logic                   lock_s;
    logic [7:0]             lost_inc;

    assign lock_s   = sync_q[SYNC_STAGES-1];
    assign lost_inc = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.CCC_LOCK};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 16'd1;
        fab_d    = fab_q;
        periph_d = periph_q;
        ready_d  = ready_q;
        lost_d   = lost_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d    = '0;
                fab_d    = 1'b0;
                periph_d = 1'b0;
                ready_d  = 1'b0;
                if (lock_s) state_d = STABLE;
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    fab_d   = 1'b1;
                end
            end
            GAP: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    fab_d   = 1'b0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    periph_d = 1'b1;
                    ready_d  = 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
                // lock loss takes priority; a coincident software request is dropped
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    fab_d    = 1'b0;
                    periph_d = 1'b0;
                    ready_d  = 1'b0;
                    lost_d   = lost_inc;
                end else if (bus.SW_RESET_REQ) begin
                    state_d  = SW_HOLD;
                    fab_d    = 1'b0;
                    periph_d = 1'b0;
                    ready_d  = 1'b0;
                end
            end
            SW_HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    lost_d  = lost_inc;
                end else if (cnt_q == HOLD_LAST) begin
                    // lock never dropped, so skip re-stabilizing and go straight to the gap
                    state_d = GAP;
                    cnt_d   = '0;
                    fab_d   = 1'b1;
                end
            end
            default: begin
                state_d  = WAIT_LOCK;
                cnt_d    = '0;
                fab_d    = 1'b0;
                periph_d = 1'b0;
                ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync_q   <= '0;
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            fab_q    <= 1'b0;
            periph_q <= 1'b0;
            ready_q  <= 1'b0;
            lost_q   <= '0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fab_q    <= fab_d;
            periph_q <= periph_d;
            ready_q  <= ready_d;
            lost_q   <= lost_d;
        end
    end

    assign bus.FAB_RESET_N    = fab_q;
    assign bus.PERIPH_RESET_N = periph_q;
    assign bus.READY          = ready_q;
    assign bus.LOCK_LOST_CNT  = lost_q;

endmodule

// File: tb/tb_fabric_reset_sequencer.sv
// Directed bench: default-parameter instance for sequencing/latency, small-parameter
// instance for counter saturation and asynchronous reset abort.
module tb_fabric_reset_sequencer;

    logic CLK = 1'b0;
    logic rstn_a;
    logic rstn_b;

    fabric_reset_sequencer_if bus_a ();
    fabric_reset_sequencer_if bus_b ();

    fabric_reset_sequencer dut_a (
        .CLK    (CLK),
        .RESETN (rstn_a),
        .bus    (bus_a)
    );

    fabric_reset_sequencer #(
        .SYNC_STAGES    (3),
        .STABLE_CYCLES  (4),
        .STAGE_GAP      (2),
        .SW_HOLD_CYCLES (3)
    ) dut_b (
        .CLK    (CLK),
        .RESETN (rstn_b),
        .bus    (bus_b)
    );

    always #10 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_item_t;

    sb_item_t sb_q[$];
    int errors = 0;
    int checks = 0;

    task automatic push(input string tag, input logic [31:0] val);
        sb_item_t it;
        it.tag = tag;
        it.val = val;
        sb_q.push_back(it);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_item_t it;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%0d expected=<none>", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.val) else begin
                errors++;
                $error("FAIL %s: observed=%0d expected=%0d", it.tag, obs, it.val);
            end
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0: return bus_a.FAB_RESET_N;
            1: return bus_a.PERIPH_RESET_N;
            2: return bus_a.READY;
            3: return bus_b.FAB_RESET_N;
            4: return bus_b.PERIPH_RESET_N;
            default: return bus_b.READY;
        endcase
    endfunction

    // Returns the number of rising edges until the selected output reaches lvl, or -1.
    task automatic wait_for(input int which, input logic lvl, input int bound, output int n);
        logic f, p, r;
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge CLK);
            f = (which < 3) ? bus_a.FAB_RESET_N    : bus_b.FAB_RESET_N;
            p = (which < 3) ? bus_a.PERIPH_RESET_N : bus_b.PERIPH_RESET_N;
            r = (which < 3) ? bus_a.READY          : bus_b.READY;
            checks++;
            assert (!(p === 1'b1 && f !== 1'b1)) else begin
                errors++;
                $error("FAIL order_inv: observed periph=%b fab=%b expected fab=1", p, f);
            end
            checks++;
            assert (r === p) else begin
                errors++;
                $error("FAIL ready_inv: observed ready=%b expected=%b", r, p);
            end
            if (sel(which) === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        bus_a.CCC_LOCK = 1'b0;
        bus_a.SW_RESET_REQ = 1'b0;
        bus_b.CCC_LOCK = 1'b0;
        bus_b.SW_RESET_REQ = 1'b0;
        repeat (3) @(negedge CLK);

        push("rst_fab", 0);    sb_check(32'(bus_a.FAB_RESET_N));
        push("rst_periph", 0); sb_check(32'(bus_a.PERIPH_RESET_N));
        push("rst_ready", 0);  sb_check(32'(bus_a.READY));
        push("rst_cnt", 0);    sb_check(32'(bus_a.LOCK_LOST_CNT));

        // Test 1: lock present at edge 0
        rstn_a = 1'b1;
        bus_a.CCC_LOCK = 1'b1;
        push("t1_fab_edge", 1026);
        wait_for(0, 1'b1, 2000, n);
        sb_check(32'(n - 1));
        push("t1_periph_gap", 16);
        wait_for(1, 1'b1, 100, n);
        sb_check(32'(n));
        push("t1_ready", 1); sb_check(32'(bus_a.READY));
        push("t1_cnt", 0);   sb_check(32'(bus_a.LOCK_LOST_CNT));

        // Test 3: lock loss in RUN
        bus_a.CCC_LOCK = 1'b0;
        push("t3_fall_lat", 3);
        wait_for(0, 1'b0, 20, n);
        sb_check(32'(n));
        push("t3_periph", 0); sb_check(32'(bus_a.PERIPH_RESET_N));
        push("t3_ready", 0);  sb_check(32'(bus_a.READY));
        push("t3_cnt", 1);    sb_check(32'(bus_a.LOCK_LOST_CNT));

        // Test 2: glitch at STABLE count 500 restarts the full count
        bus_a.CCC_LOCK = 1'b1;
        repeat (503) @(negedge CLK);
        push("t2_fab_held", 0); sb_check(32'(bus_a.FAB_RESET_N));
        bus_a.CCC_LOCK = 1'b0;
        repeat (3) @(negedge CLK);
        bus_a.CCC_LOCK = 1'b1;
        push("t2_restart", 1027);
        wait_for(0, 1'b1, 2000, n);
        sb_check(32'(n));
        push("t2_periph_gap", 16);
        wait_for(1, 1'b1, 100, n);
        sb_check(32'(n));
        push("t2_cnt", 1); sb_check(32'(bus_a.LOCK_LOST_CNT));

        // Test 4: software reset from RUN
        bus_a.SW_RESET_REQ = 1'b1;
        @(negedge CLK);
        bus_a.SW_RESET_REQ = 1'b0;
        push("t4_fab_low", 0);    sb_check(32'(bus_a.FAB_RESET_N));
        push("t4_periph_low", 0); sb_check(32'(bus_a.PERIPH_RESET_N));
        push("t4_ready_low", 0);  sb_check(32'(bus_a.READY));
        push("t4_hold", 32);
        wait_for(0, 1'b1, 100, n);
        sb_check(32'(n));
        push("t4_periph_gap", 16);
        wait_for(1, 1'b1, 100, n);
        sb_check(32'(n));
        push("t4_cnt", 1); sb_check(32'(bus_a.LOCK_LOST_CNT));

        // Test 5: request coincident with lock_s falling; lock loss wins
        bus_a.CCC_LOCK = 1'b0;
        repeat (2) @(negedge CLK);
        bus_a.SW_RESET_REQ = 1'b1;
        @(negedge CLK);
        bus_a.SW_RESET_REQ = 1'b0;
        push("t5_fab_low", 0); sb_check(32'(bus_a.FAB_RESET_N));
        push("t5_cnt", 2);     sb_check(32'(bus_a.LOCK_LOST_CNT));
        bus_a.CCC_LOCK = 1'b1;
        repeat (300) @(negedge CLK);
        bus_a.SW_RESET_REQ = 1'b1;
        @(negedge CLK);
        bus_a.SW_RESET_REQ = 1'b0;
        push("t5_stable_sw", 1027 - 301);
        wait_for(0, 1'b1, 2000, n);
        sb_check(32'(n));
        push("t5_periph_gap", 16);
        wait_for(1, 1'b1, 100, n);
        sb_check(32'(n));
        push("t5_cnt_after", 2); sb_check(32'(bus_a.LOCK_LOST_CNT));

        // Test 6: small-parameter instance
        rstn_b = 1'b1;
        bus_b.CCC_LOCK = 1'b1;
        push("t6_b_fab_lat", 8);
        wait_for(3, 1'b1, 100, n);
        sb_check(32'(n));
        push("t6_b_periph_gap", 2);
        wait_for(4, 1'b1, 100, n);
        sb_check(32'(n));
        for (int i = 0; i < 300; i++) begin
            wait_for(5, 1'b1, 50, n);
            bus_b.CCC_LOCK = 1'b0;
            wait_for(5, 1'b0, 50, n);
            bus_b.CCC_LOCK = 1'b1;
            if (i == 0) begin
                push("t6_cnt_first", 1);
                sb_check(32'(bus_b.LOCK_LOST_CNT));
            end
            if (i == 254) begin
                push("t6_cnt_255", 255);
                sb_check(32'(bus_b.LOCK_LOST_CNT));
            end
        end
        push("t6_cnt_sat", 255); sb_check(32'(bus_b.LOCK_LOST_CNT));

        wait_for(3, 1'b1, 100, n);
        push("t6_in_gap", 0); sb_check(32'(bus_b.PERIPH_RESET_N));
        rstn_b = 1'b0;
        #1;
        push("t6_abort_fab", 0);    sb_check(32'(bus_b.FAB_RESET_N));
        push("t6_abort_periph", 0); sb_check(32'(bus_b.PERIPH_RESET_N));
        push("t6_abort_ready", 0);  sb_check(32'(bus_b.READY));
        push("t6_abort_cnt", 0);    sb_check(32'(bus_b.LOCK_LOST_CNT));
        @(negedge CLK);
        rstn_b = 1'b1;
        push("t6_restart_lat", 8);
        wait_for(3, 1'b1, 100, n);
        sb_check(32'(n));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
